// File: rtl/data_mem_responder_if.sv
// CPU MEM-stage data port: one request channel plus a single-cycle completion channel.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_op;
  logic        req_we;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_op, req_we,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_op, req_we,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: serialises one load/store at a time onto a multi-cycle byte-enabled
// synchronous SRAM and returns extended load data with a one-cycle completion pulse.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus,
  output logic                  sram_cs_o,
  output logic                  sram_we_o,
  output logic [3:0]            sram_be_o,
  output logic [ADDR_W-3:0]     sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              req_ready_q;
  logic              sram_cs_q;
  logic              sram_we_q;
  logic [3:0]        sram_be_q;
  logic [ADDR_W-3:0] sram_addr_q;
  logic [31:0]       sram_wdata_q;
  logic [31:0]       rsp_rdata_q;
  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;

  // Request decode, evaluated on the incoming (not yet latched) request.
  logic [1:0]  req_size;
  logic        addr_oob;
  logic        req_err;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  always_comb begin
    req_size = bus.req_op[1:0];
    addr_oob = |(bus.req_addr >> ADDR_W);
    req_err  = (req_size == 2'b11) | bus.req_op[3] | addr_oob
             | ((req_size == 2'b01) & bus.req_addr[0])
             | ((req_size == 2'b10) & (|bus.req_addr[1:0]));
    be_in    = 4'b0000;
    wdata_in = bus.req_wdata;
    case (req_size)
      2'b00: begin
        be_in    = 4'b0001 << bus.req_addr[1:0];
        wdata_in = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_in    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = bus.req_wdata;
      end
    endcase
  end

  // Little-endian lane selection and extension of the SRAM read word.
  logic [31:0] lane_word;
  logic [31:0] load_ext;

  always_comb begin
    lane_word = sram_rdata_i >> {addr_lo_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_ext = {{16{~uns_q & lane_word[15]}}, lane_word[15:0]};
      default: load_ext = lane_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      sram_cs_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= 4'b0000;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      rsp_rdata_q  <= 32'h0;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            addr_lo_q   <= bus.req_addr[1:0];
            size_q      <= req_size;
            uns_q       <= bus.req_op[2];
            we_q        <= bus.req_we;
            if (req_err) begin
              state_q     <= StErr;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q      <= StAccess;
              cnt_q        <= 4'(WAIT_STATES);
              sram_cs_q    <= 1'b1;
              sram_we_q    <= bus.req_we;
              sram_be_q    <= be_in;
              sram_addr_q  <= bus.req_addr[ADDR_W-1:2];
              sram_wdata_q <= wdata_in;
            end
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            state_q     <= StResp;
            sram_cs_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_be_q   <= 4'b0000;
            rsp_rdata_q <= we_q ? 32'h0 : load_ext;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp, StErr: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The completion pulse decodes straight from state so it lines up with rsp_rdata_q.
  assign bus.rsp_valid = (state_q == StResp) || (state_q == StErr);
  assign bus.rsp_err   = (state_q == StErr);
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign sram_cs_o    = sram_cs_q;
  assign sram_we_o    = sram_we_q;
  assign sram_be_o    = sram_be_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's MEM-stage data port: accepts one load/store request at a time and drives a multi-cycle synchronous SRAM with byte enables.
- Returns aligned, sign/zero-extended load data plus a completion pulse.
- Deasserts req_ready while busy; the pipeline uses it as the MEM-stage stall.
- Replaces the single-cycle data cache path once SRAM latency exceeds one cycle.

Parameters:
- ADDR_W, 12, byte-address width of the SRAM window (4 KiB default).
- WAIT_STATES, 2, extra cycles sram_cs stays asserted before read data is valid. Range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  responder idle; request accepted when req_valid & req_ready
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_op  in  4  [1:0] size: 00 byte, 01 half, 10 word, 11 illegal; [2] unsigned load; [3] reserved, must be 0
- req_we  in  1  1 = store, 0 = load
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; misaligned, illegal op, or out-of-range
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write strobe
- sram_be  out  4  byte-lane enables, lane i = bits [8i+7:8i]
- sram_addr  out  ADDR_W-2  word address
- sram_wdata  out  32  lane-replicated store data
- sram_rdata  in  32  SRAM read data, valid on the last cycle of cs

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1.
  - rsp_valid, rsp_err, sram_cs, sram_we = 0.
  - sram_be, sram_addr, sram_wdata, rsp_rdata = 0.
  - Reset during ACCESS aborts the access immediately: cs drops asynchronously and no response is issued.
- Byte order is little-endian: lane = addr[1:0].
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr, op, we, wdata; req_ready falls next cycle.
  - Error conditions: op[1:0]=11; op[3]=1; half with addr[0]=1; word with addr[1:0]!=0; req_addr[31:ADDR_W]!=0.
  - Any error -> ERR. Otherwise -> ACCESS with wait counter = WAIT_STATES.
- ERR:
  - One cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - No SRAM activity.
  - -> IDLE.
- ACCESS:
  - sram_cs=1 and sram_we=latched we, held for WAIT_STATES+1 cycles.
  - sram_addr=addr[ADDR_W-1:2].
  - sram_be: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111. Same for loads and stores.
  - sram_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
  - Counter decrements each cycle. When it is 0: capture sram_rdata on a load, -> RESP.
- RESP:
  - One cycle: rsp_valid=1, rsp_err=0, sram_cs=0.
  - Load: selected lane(s) right-justified; sign-extended if op[2]=0, zero-extended if op[2]=1.
  - Store: rsp_rdata=0.
  - -> IDLE.
- Latency: handshake at edge T -> cs high cycles T+1..T+1+WAIT_STATES -> rsp_valid at cycle T+2+WAIT_STATES -> req_ready=1 at T+3+WAIT_STATES. Error response comes at T+1.
- Throughput: one request per WAIT_STATES+3 cycles. No back-to-back acceptance in the RESP cycle.
- While busy, req_valid and all request inputs are ignored; latched values are used. Dropping req_valid does not cancel an access.
- rsp_rdata holds its value until the next rsp_valid.
- Outputs other than rsp_valid and rsp_err are registered.
- WAIT_STATES=0 gives a single-cycle cs.

Test Plan:
1. Reset, then word store addr=0x10, wdata=0xDEADBEEF, WAIT_STATES=2 -> cs high 3 cycles, be=1111, sram_addr=4, sram_wdata=0xDEADBEEF; rsp_valid 4 cycles after handshake, rsp_err=0, rsp_rdata=0.
2. Byte load addr=0x13, signed, sram_rdata=0x80112233 -> be=1000, rsp_rdata=0xFFFFFF80. Repeat with op[2]=1 -> 0x00000080.
3. Half store addr=0x22, wdata=0x0000ABCD -> be=1100, sram_wdata=0xABCDABCD. Half signed load at addr=0x20 with sram_rdata=0x1234F00D -> 0xFFFFF00D.
4. Error cases:
   - Word load addr=0x02 -> rsp_valid with rsp_err=1 one cycle after handshake, sram_cs never asserted.
   - op=4'b0011 -> same error response.
   - addr=0x1000 with ADDR_W=12 -> same error response.
5. Hold req_valid=1 with changing addr during ACCESS -> only the first request is serviced; req_ready low until the cycle after rsp_valid; second request accepted only then.
6. Assert rst_n=0 mid-ACCESS (cycle 2 of 3) -> sram_cs=0 immediately, no rsp_valid; after release req_ready=1 and a new load completes normally.
